// File: rtl/game_pkg.sv
// Shared types and constants for the match scoring logic.
// Player lifecycle states, death/gold counter widths and the gold ceiling.
package game_pkg;

    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        DEAD_WAIT = 2'd1,
        OUT       = 2'd2
    } player_st_t;

    localparam int DEATH_W  = 2;
    localparam int GOLD_W   = 3;
    localparam int GOLD_MAX = 7;
    localparam int TICK_W   = 4;

endpackage

// File: rtl/player_life_ctrl.sv
// One player's life cycle: death count, respawn countdown and gold count.
// Gold counting is built only when SCORE_GOLD_EN is defined; otherwise the
// gold output is tied to zero and no gold register exists.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ALIVE     | tank on the field, hits and gold are counted
//   DEAD_WAIT | destroyed, counting slow ticks down to the respawn pulse
//   OUT       | death limit reached, stays here until idle or reset
module player_life_ctrl
    import game_pkg::*;
#(
    parameter int RESPAWN_TICKS = 3,
    parameter int MAX_DEATHS    = 3
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               slow_tick_i,
    input  logic               enable_i,
    input  logic               idle_i,
    input  logic               hit_i,
    input  logic               gold_i,
    output logic [DEATH_W-1:0] deathcount_o,
    output logic [GOLD_W-1:0]  num_of_gold_o,
    output logic               alive_o,
    output logic               respawn_o
);

    localparam logic [TICK_W-1:0]  RESPAWN_LD = TICK_W'(RESPAWN_TICKS);
    localparam logic [DEATH_W-1:0] DEATH_LIM  = DEATH_W'(MAX_DEATHS);

    player_st_t         state_q, state_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [DEATH_W-1:0] death_q, death_d;
    logic               respawn_q, respawn_d;
    logic [DEATH_W-1:0] death_inc;

    assign death_inc = death_q + 1'b1;

    // State, countdown, death count and respawn pulse registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ALIVE;
            tick_q    <= '0;
            death_q   <= '0;
            respawn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            death_q   <= death_d;
            respawn_q <= respawn_d;
        end
    end

    // Next-state logic; idle beats everything, a low enable freezes everything
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        death_d   = death_q;
        respawn_d = 1'b0;
        if (idle_i) begin
            state_d = ALIVE;
            tick_d  = '0;
            death_d = '0;
        end else if (enable_i) begin
            unique case (state_q)
                ALIVE: begin
                    if (hit_i) begin
                        death_d = death_inc;
                        if (death_inc == DEATH_LIM) begin
                            state_d = OUT;
                        end else begin
                            state_d = DEAD_WAIT;
                            tick_d  = RESPAWN_LD;
                        end
                    end
                end
                DEAD_WAIT: begin
                    if (slow_tick_i) begin
                        tick_d = tick_q - 1'b1;
                        if (tick_q == TICK_W'(1)) begin
                            state_d   = ALIVE;
                            respawn_d = 1'b1;
                        end
                    end
                end
                OUT: begin
                    state_d = OUT;
                end
                default: begin
                    state_d = ALIVE;
                    tick_d  = '0;
                end
            endcase
        end
    end

    assign deathcount_o = death_q;
    assign alive_o      = (state_q == ALIVE);
    assign respawn_o    = respawn_q;

`ifdef SCORE_GOLD_EN
    logic [GOLD_W-1:0] gold_q, gold_d;

    // Gold register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            gold_q <= '0;
        end else begin
            gold_q <= gold_d;
        end
    end

    // Gold counts only while alive and in play; a same-cycle hit drops it
    always_comb begin
        gold_d = gold_q;
        if (idle_i) begin
            gold_d = '0;
        end else if (enable_i && (state_q == ALIVE) && gold_i && !hit_i
                     && (gold_q != GOLD_W'(GOLD_MAX))) begin
            gold_d = gold_q + 1'b1;
        end
    end

    assign num_of_gold_o = gold_q;
`else
    logic unused_gold;
    assign unused_gold   = gold_i;
    assign num_of_gold_o = '0;
`endif

endmodule

// File: rtl/match_score_ctrl.sv
// Match scoring top: two independent player life controllers.
// Gold counting is included only when SCORE_GOLD_EN is defined.
module match_score_ctrl
    import game_pkg::*;
#(
    parameter int RESPAWN_TICKS = 3,
    parameter int MAX_DEATHS    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               slowClken,
    input  logic               enable_game,
    input  logic               idle,
    input  logic               hit1,
    input  logic               hit2,
    input  logic               gold1,
    input  logic               gold2,
    output logic [DEATH_W-1:0] deathcount1,
    output logic [DEATH_W-1:0] deathcount2,
    output logic [GOLD_W-1:0]  num_of_gold1,
    output logic [GOLD_W-1:0]  num_of_gold2,
    output logic               alive1,
    output logic               alive2,
    output logic               respawn1,
    output logic               respawn2
);

    player_life_ctrl #(
        .RESPAWN_TICKS(RESPAWN_TICKS),
        .MAX_DEATHS   (MAX_DEATHS)
    ) u_player1 (
        .clk_i        (clk),
        .reset_i      (reset),
        .slow_tick_i  (slowClken),
        .enable_i     (enable_game),
        .idle_i       (idle),
        .hit_i        (hit1),
        .gold_i       (gold1),
        .deathcount_o (deathcount1),
        .num_of_gold_o(num_of_gold1),
        .alive_o      (alive1),
        .respawn_o    (respawn1)
    );

    player_life_ctrl #(
        .RESPAWN_TICKS(RESPAWN_TICKS),
        .MAX_DEATHS   (MAX_DEATHS)
    ) u_player2 (
        .clk_i        (clk),
        .reset_i      (reset),
        .slow_tick_i  (slowClken),
        .enable_i     (enable_game),
        .idle_i       (idle),
        .hit_i        (hit2),
        .gold_i       (gold2),
        .deathcount_o (deathcount2),
        .num_of_gold_o(num_of_gold2),
        .alive_o      (alive2),
        .respawn_o    (respawn2)
    );

endmodule

// File: tb/tb_match_score_ctrl.sv
// Directed bench for match_score_ctrl with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after the rising edge that consumed them.
module tb_match_score_ctrl;

`ifdef SCORE_GOLD_EN
    localparam int GOLD_ON = 1;
`else
    localparam int GOLD_ON = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       slowClken, enable_game, idle;
    logic       hit1, hit2, gold1, gold2;
    logic [1:0] deathcount1, deathcount2;
    logic [2:0] num_of_gold1, num_of_gold2;
    logic       alive1, alive2, respawn1, respawn2;

    int n_cmp = 0;
    int n_bad = 0;
    int tally_a, tally_b;

    match_score_ctrl #(.RESPAWN_TICKS(3), .MAX_DEATHS(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .slowClken   (slowClken),
        .enable_game (enable_game),
        .idle        (idle),
        .hit1        (hit1),
        .hit2        (hit2),
        .gold1       (gold1),
        .gold2       (gold2),
        .deathcount1 (deathcount1),
        .deathcount2 (deathcount2),
        .num_of_gold1(num_of_gold1),
        .num_of_gold2(num_of_gold2),
        .alive1      (alive1),
        .alive2      (alive2),
        .respawn1    (respawn1),
        .respawn2    (respawn2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the given pulses; returns on the next falling edge.
    task automatic step(input logic h1, input logic h2, input logic g1,
                        input logic g2, input logic tk, input logic id);
        hit1 = h1; hit2 = h2; gold1 = g1; gold2 = g2;
        slowClken = tk; idle = id;
        @(negedge clk);
        hit1 = 0; hit2 = 0; gold1 = 0; gold2 = 0; slowClken = 0; idle = 0;
    endtask

    initial begin
        reset = 1; enable_game = 0; slowClken = 0; idle = 0;
        hit1 = 0; hit2 = 0; gold1 = 0; gold2 = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_dc1", deathcount1, 0);
        chk("rst_dc2", deathcount2, 0);
        chk("rst_alive1", alive1, 1);
        chk("rst_alive2", alive2, 1);
        chk("rst_resp1", respawn1, 0);
        chk("rst_gold1", num_of_gold1, 0);
        reset = 0;
        enable_game = 1;
        @(negedge clk);

        // Hit, ignored re-hit, 3-tick respawn
        step(1, 0, 0, 0, 0, 0);
        chk("h1_dc1", deathcount1, 1);
        chk("h1_alive1", alive1, 0);
        chk("h1_alive2", alive2, 1);
        step(1, 0, 0, 0, 0, 0);
        chk("h1_rehit_dc1", deathcount1, 1);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("h1_t2_alive1", alive1, 0);
        chk("h1_t2_resp1", respawn1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("h1_t3_resp1", respawn1, 1);
        chk("h1_t3_alive1", alive1, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("h1_after_resp1", respawn1, 0);
        chk("h1_after_alive1", alive1, 1);

        // Player 2 runs out of lives
        for (int k = 1; k <= 3; k++) begin
            step(0, 1, 0, 0, 0, 0);
            chk($sformatf("p2_dc_%0d", k), deathcount2, k);
            chk($sformatf("p2_alive_%0d", k), alive2, 0);
            if (k < 3) begin
                step(0, 0, 0, 0, 1, 0);
                step(0, 0, 0, 0, 1, 0);
                step(0, 0, 0, 0, 1, 0);
                chk($sformatf("p2_resp_%0d", k), respawn2, 1);
            end
        end
        tally_a = 0; tally_b = 0;
        for (int t = 0; t < 20; t++) begin
            step(0, (t == 5), 0, 0, 1, 0);
            tally_a += respawn2;
            tally_b += alive2;
        end
        chk("p2_out_resp", tally_a, 0);
        chk("p2_out_alive", tally_b, 0);
        chk("p2_out_dc_sat", deathcount2, 3);

        // Gold saturation and hit-over-gold
        for (int g = 0; g < 4; g++) step(0, 0, 1, 0, 0, 0);
        chk("g1_four", num_of_gold1, GOLD_ON ? 4 : 0);
        for (int g = 0; g < 5; g++) step(0, 0, 1, 0, 0, 0);
        chk("g1_sat", num_of_gold1, GOLD_ON ? 7 : 0);
        step(0, 0, 0, 1, 0, 0);
        chk("g2_out_ignored", num_of_gold2, 0);
        step(1, 0, 1, 0, 0, 0);
        chk("hg_gold1", num_of_gold1, GOLD_ON ? 7 : 0);
        chk("hg_dc1", deathcount1, 2);

        // idle overrides hit, gold and tick in the same cycle
        step(1, 1, 1, 1, 1, 1);
        chk("idle_dc1", deathcount1, 0);
        chk("idle_dc2", deathcount2, 0);
        chk("idle_gold1", num_of_gold1, 0);
        chk("idle_alive1", alive1, 1);
        chk("idle_alive2", alive2, 1);

        // Simultaneous hits, then idle mid-countdown
        step(1, 1, 0, 0, 0, 0);
        chk("both_dc1", deathcount1, 1);
        chk("both_dc2", deathcount2, 1);
        chk("both_alive1", alive1, 0);
        chk("both_alive2", alive2, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("idlew_dc1", deathcount1, 0);
        chk("idlew_dc2", deathcount2, 0);
        chk("idlew_alive1", alive1, 1);
        chk("idlew_alive2", alive2, 1);
        tally_a = respawn1 + respawn2;
        for (int t = 0; t < 5; t++) begin
            step(0, 0, 0, 0, 1, 0);
            tally_a += respawn1 + respawn2;
        end
        chk("idlew_no_resp", tally_a, 0);

        // Freeze while enable_game is low
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 1, 0);
        chk("dw_gold_ignored", num_of_gold1, 0);
        enable_game = 0;
        tally_a = 0; tally_b = 0;
        for (int t = 0; t < 10; t++) begin
            step(0, 1, 0, 1, 1, 0);
            tally_a += respawn1;
            tally_b += alive1;
        end
        chk("frz_resp1", tally_a, 0);
        chk("frz_alive1", tally_b, 0);
        chk("frz_dc2", deathcount2, 0);
        chk("frz_gold2", num_of_gold2, 0);
        enable_game = 1;
        step(0, 0, 0, 0, 1, 0);
        chk("frz_t3_resp1", respawn1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("frz_t4_resp1", respawn1, 1);
        chk("frz_t4_alive1", alive1, 1);

        // Gold counts for player 2 while alive
        step(0, 0, 0, 1, 0, 0);
        chk("g2_alive", num_of_gold2, GOLD_ON ? 1 : 0);

        // Asynchronous reset mid-countdown
        step(0, 1, 0, 0, 0, 0);
        chk("rw_dc2", deathcount2, 1);
        #2 reset = 1;
        #1;
        chk("rw_async_dc2", deathcount2, 0);
        chk("rw_async_alive2", alive2, 1);
        chk("rw_async_gold2", num_of_gold2, 0);
        @(negedge clk);
        reset = 0;
        tally_a = 0;
        for (int t = 0; t < 5; t++) begin
            step(0, 0, 0, 0, 1, 0);
            tally_a += respawn2;
        end
        chk("rw_no_resp2", tally_a, 0);
        chk("rw_alive2", alive2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
